dmem_resp: RTL and testbench

- Data-memory responder: the slave end of the core's MEM-stage data port (mem_addr, mem_wdata, mem_type, mem_sign, rmem, wmem, mem_rdata).
- Holds a word-organised RAM with byte-lane writes, load extraction and sign extension, and misalignment/range checking.
- Faults are captured by a sticky capture FSM.
- Sits beside the core in the SoC top. Load data is returned in the same cycle, because the core registers mem_rdata at the MEM/WB boundary.

---
 rtl/dmem_resp_pkg.sv | 39 +++
 rtl/dmem_align.sv | 62 ++++++
 rtl/dmem_resp.sv | 187 ++++++++++++++++++
 tb/tb_dmem_resp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared types, encodings and helpers for the data-memory responder.
// Defines the `MEM_TYPE_BUS macro used for the access-size port on
// dmem_resp and dmem_align.
`ifndef DMEM_RESP_DEFINES
`define DMEM_RESP_DEFINES
`define MEM_TYPE_BUS [1:0]
`endif

package dmem_resp_pkg;

    localparam int unsigned DATA_W = 32;

    // Access-size encodings (mem_type)
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Fault cause codes
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_PROTO    = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FAULT = 1'b1
    } cap_state_e;

    // Right-justified byte, sign- or zero-extended to a full word
    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        return sgn ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

    // Right-justified halfword, sign- or zero-extended to a full word
    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
        return sgn ? {{16{h[15]}}, h} : {16'd0, h};
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic for the data-memory responder.
// Ports:
//   addr_lo     in   byte offset within the word
//   mem_type    in   access size (byte/half/word)
//   mem_sign    in   1 = sign-extend loads
//   raw_word    in   RAM word at the addressed index
//   wdata       in   right-aligned store data
//   ld_data     out  extracted, extended load data
//   lane_be     out  byte-lane write mask
//   wdata_rep   out  store data replicated into all candidate lanes
//   misaligned  out  access violates alignment (or unknown size)
module dmem_align
    import dmem_resp_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic `MEM_TYPE_BUS mem_type,
    input  logic              mem_sign,
    input  logic [DATA_W-1:0] raw_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data,
    output logic [3:0]        lane_be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic              misaligned
);

    logic [DATA_W-1:0] byte_shift;
    logic [15:0]       half_sel;

    assign byte_shift = raw_word >> {addr_lo, 3'b000};
    assign half_sel   = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    // Size decode; unknown encodings report misaligned with no lanes enabled
    always_comb begin
        ld_data    = '0;
        lane_be    = '0;
        wdata_rep  = '0;
        misaligned = 1'b0;
        case (mem_type)
            MEM_BYTE: begin
                ld_data   = ext_byte(byte_shift[7:0], mem_sign);
                lane_be   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_HALF: begin
                misaligned = addr_lo[0];
                ld_data    = ext_half(half_sel, mem_sign);
                lane_be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
            end
            MEM_WORD: begin
                misaligned = |addr_lo;
                ld_data    = raw_word;
                lane_be    = 4'b1111;
                wdata_rep  = wdata;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: slave end of the core's MEM-stage data port.
// Word-organised RAM with byte-lane stores, same-cycle load extraction,
// range/alignment/protocol checking and a sticky first-fault capture.
// Ports:
//   clk, rstn              clock; synchronous reset, active-high
//   mem_addr/mem_wdata     byte address and right-aligned store data
//   mem_type/mem_sign      access size and load sign extension
//   rmem/wmem              load / store request
//   mem_rdata              combinational load data
//   err_o/err_addr_o/err_cause_o  sticky fault flag, address, cause
//   err_clr                clears the sticky fault
// Optional (DMEM_ACCESS_CNT_EN): ld_cnt_o/st_cnt_o legal access counters.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic `MEM_TYPE_BUS mem_type,
    input  logic              mem_sign,
    input  logic              rmem,
    input  logic              wmem,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              err_o,
    output logic [AW-1:0]     err_addr_o,
    output logic [1:0]        err_cause_o,
    input  logic              err_clr
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       ld_cnt_o,
    output logic [31:0]       st_cnt_o
`endif
);

    localparam int unsigned   IW         = $clog2(DEPTH);
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH * 4);

    logic [DATA_W-1:0] ram_q [DEPTH];

    logic [IW-1:0]     word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ld_data;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] wdata_rep;
    logic              misaligned;
    logic              out_of_range;
    logic              both_req;
    logic              fault;
    logic [1:0]        cause;
    logic              legal_ld;
    logic              legal_st;
    logic              st_en;

    cap_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic [1:0]        err_cause_q, err_cause_d;

    assign word_idx = mem_addr[IW+1:2];
    assign rd_word  = ram_q[word_idx];

    dmem_align u_align (
        .addr_lo    (mem_addr[1:0]),
        .mem_type   (mem_type),
        .mem_sign   (mem_sign),
        .raw_word   (rd_word),
        .wdata      (mem_wdata),
        .ld_data    (ld_data),
        .lane_be    (lane_be),
        .wdata_rep  (wdata_rep),
        .misaligned (misaligned)
    );

    // Fault classification; protocol beats range beats alignment
    always_comb begin
        out_of_range = (mem_addr >= ADDR_LIMIT);
        both_req     = rmem & wmem;
        fault        = (rmem | wmem) & (misaligned | out_of_range | both_req);
        if (both_req) begin
            cause = ERR_PROTO;
        end else if (out_of_range) begin
            cause = ERR_RANGE;
        end else begin
            cause = ERR_MISALIGN;
        end
        legal_ld  = rmem & ~fault;
        legal_st  = wmem & ~fault;
        st_en     = legal_st & ~rstn;
        mem_rdata = legal_ld ? ld_data : '0;
    end

    // Byte-lane RAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    ram_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Capture FSM next state: first fault wins until cleared
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (fault) begin
                    state_d     = ST_FAULT;
                    err_d       = 1'b1;
                    err_addr_d  = mem_addr;
                    err_cause_d = cause;
                end
            end
            ST_FAULT: begin
                if (err_clr) begin
                    if (fault) begin
                        err_addr_d  = mem_addr;
                        err_cause_d = cause;
                    end else begin
                        state_d     = ST_IDLE;
                        err_d       = 1'b0;
                        err_addr_d  = '0;
                        err_cause_d = ERR_NONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;
    assign err_cause_o = err_cause_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_cnt_q, ld_cnt_d;
    logic [31:0] st_cnt_q, st_cnt_d;

    // Legal-access counters; wrap naturally, cleared with the fault flag
    always_comb begin
        ld_cnt_d = ld_cnt_q + 32'(legal_ld);
        st_cnt_d = st_cnt_q + 32'(legal_st);
        if (err_clr) begin
            ld_cnt_d = '0;
            st_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign ld_cnt_o = ld_cnt_q;
    assign st_cnt_o = st_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp (DEPTH=1024, AW=32).
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic        mem_sign;
    logic        rmem;
    logic        wmem;
    logic [31:0] mem_rdata;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic [1:0]  err_cause_o;
    logic        err_clr;
`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_cnt_o;
    logic [31:0] st_cnt_o;
`endif

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(1024), .AW(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_type    (mem_type),
        .mem_sign    (mem_sign),
        .rmem        (rmem),
        .wmem        (wmem),
        .mem_rdata   (mem_rdata),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_cause_o (err_cause_o),
        .err_clr     (err_clr)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .ld_cnt_o    (ld_cnt_o),
        .st_cnt_o    (st_cnt_o)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  ty;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] B  = MEM_BYTE;
    localparam logic [1:0] H  = MEM_HALF;
    localparam logic [1:0] W  = MEM_WORD;
    localparam logic [1:0] BAD = 2'b11;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] ty,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                input logic clr, input logic [31:0] er, input logic ee,
                                input logic [31:0] ea, input logic [1:0] ec);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ty = ty; v.sg = sg; v.addr = a; v.wdata = wd;
        v.clr = clr; v.exp_rdata = er; v.exp_err = ee; v.exp_addr = ea; v.exp_cause = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] ty, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic clr);
        rmem = rd; wmem = wr; mem_type = ty; mem_sign = sg;
        mem_addr = a; mem_wdata = wd; err_clr = clr;
    endtask

    task automatic chk_flags(input string nm, input int idx, input logic ee,
                             input logic [31:0] ea, input logic [1:0] ec);
        chk({nm, "_err_o"}, idx, 32'(err_o), 32'(ee));
        chk({nm, "_err_addr"}, idx, err_addr_o, ea);
        chk({nm, "_err_cause"}, idx, 32'(err_cause_o), 32'(ec));
    endtask

    initial begin
        //           rd wr ty  sg addr        wdata        clr exp_rdata    err addr        cause
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(0, 1, W, 0, 32'h0,    32'hCAFEF00D, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(0, 1, W, 0, 32'h4,    32'h55AA55AA, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(0, 1, W, 0, 32'h10,   32'h80C0FFEE, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, W, 0, 32'h10,   32'h0,        0, 32'h80C0FFEE, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, B, 1, 32'h13,   32'h0,        0, 32'hFFFFFF80, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, B, 0, 32'h13,   32'h0,        0, 32'h00000080, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, H, 1, 32'h12,   32'h0,        0, 32'hFFFF80C0, 0, 32'h0,    2'd0));
        vecs.push_back(mk(0, 1, W, 0, 32'h20,   32'h11223344, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(0, 1, H, 0, 32'h22,   32'h1234BEEF, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, W, 0, 32'h20,   32'h0,        0, 32'hBEEF3344, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, H, 1, 32'h22,   32'h0,        0, 32'hFFFFBEEF, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, H, 0, 32'h20,   32'h0,        0, 32'h00003344, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, B, 1, 32'h22,   32'h0,        0, 32'hFFFFFFEF, 0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, B, 1, 32'h21,   32'h0,        0, 32'h00000033, 0, 32'h0,    2'd0));
        vecs.push_back(mk(0, 1, B, 0, 32'h11,   32'h000000AB, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, W, 0, 32'h10,   32'h0,        0, 32'h80C0ABEE, 0, 32'h0,    2'd0));
        // misaligned word store, then a second fault that must not overwrite
        vecs.push_back(mk(0, 1, W, 0, 32'h6,    32'hDEADBEEF, 0, 32'h0,        1, 32'h6,    2'd1));
        vecs.push_back(mk(1, 0, W, 0, 32'h9,    32'h0,        0, 32'h0,        1, 32'h6,    2'd1));
        vecs.push_back(mk(1, 0, W, 0, 32'h4,    32'h0,        0, 32'h55AA55AA, 1, 32'h6,    2'd1));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        // first address past the end
        vecs.push_back(mk(1, 0, W, 0, 32'h1000, 32'h0,        0, 32'h0,        1, 32'h1000, 2'd2));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        // simultaneous load and store: store suppressed
        vecs.push_back(mk(1, 1, W, 0, 32'h0,    32'h12345678, 0, 32'h0,        1, 32'h0,    2'd3));
        // clear together with a new fault in FAULT: new fault latched
        vecs.push_back(mk(1, 0, H, 0, 32'h3,    32'h0,        1, 32'h0,        1, 32'h3,    2'd1));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, W, 0, 32'h0,    32'h0,        0, 32'hCAFEF00D, 0, 32'h0,    2'd0));
        // clear in IDLE with a fault: fault wins
        vecs.push_back(mk(1, 0, W, 0, 32'h2,    32'h0,        1, 32'h0,        1, 32'h2,    2'd1));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        // out of range and misaligned: range has priority
        vecs.push_back(mk(1, 0, W, 0, 32'h1001, 32'h0,        0, 32'h0,        1, 32'h1001, 2'd2));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        // unknown size encoding
        vecs.push_back(mk(1, 0, BAD, 0, 32'h0,  32'h0,        0, 32'h0,        1, 32'h0,    2'd1));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        // protocol beats range and alignment
        vecs.push_back(mk(1, 1, W, 0, 32'h1003, 32'h0,        0, 32'h0,        1, 32'h1003, 2'd3));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        // misaligned half store leaves RAM alone
        vecs.push_back(mk(0, 1, H, 0, 32'h1,    32'h0000FFFF, 0, 32'h0,        1, 32'h1,    2'd1));
        vecs.push_back(mk(0, 0, W, 0, 32'h0,    32'h0,        1, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, W, 0, 32'h0,    32'h0,        0, 32'hCAFEF00D, 0, 32'h0,    2'd0));
        // last byte in range
        vecs.push_back(mk(0, 1, B, 0, 32'hFFF,  32'h0000005A, 0, 32'h0,        0, 32'h0,    2'd0));
        vecs.push_back(mk(1, 0, B, 1, 32'hFFF,  32'h0,        0, 32'h0000005A, 0, 32'h0,    2'd0));

        rstn = 1'b1;
        drive(0, 0, W, 0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 0, 1'b0, 32'h0, 2'd0);
        chk("reset_rdata", 0, mem_rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].ty, vecs[i].sg, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
            #1;
            chk("vec_rdata", i, mem_rdata, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
            chk_flags("vec", i, vecs[i].exp_err, vecs[i].exp_addr, vecs[i].exp_cause);
        end

        // read-after-write at 0x30: store cycle still sees old word
        @(negedge clk);
        drive(0, 1, W, 0, 32'h30, 32'h0BADF00D, 0);
        @(negedge clk);
        drive(0, 1, W, 0, 32'h30, 32'h600DCAFE, 0);
        #1;
        chk("raw_same_cycle", 0, dut.rd_word, 32'h0BADF00D);
        @(negedge clk);
        drive(1, 0, W, 0, 32'h30, 32'h0, 0);
        #1;
        chk("raw_next_cycle", 0, mem_rdata, 32'h600DCAFE);

        // reset during a pending fault and a store
        @(negedge clk);
        drive(1, 0, W, 0, 32'h6, 32'h0, 0);
        @(posedge clk);
        #1;
        chk_flags("pre_rst", 0, 1'b1, 32'h6, 2'd1);
        @(negedge clk);
        rstn = 1'b1;
        drive(0, 1, W, 0, 32'h30, 32'hFFFFFFFF, 0);
        @(posedge clk);
        #1;
        chk_flags("mid_rst", 0, 1'b0, 32'h0, 2'd0);
        @(negedge clk);
        rstn = 1'b0;
        drive(1, 0, W, 0, 32'h30, 32'h0, 0);
        #1;
        chk("rst_store_dropped", 0, mem_rdata, 32'h600DCAFE);

`ifdef DMEM_ACCESS_CNT_EN
        @(negedge clk);
        drive(0, 0, W, 0, 32'h0, 32'h0, 1);
        @(posedge clk);
        #1;
        chk("cnt_clr_ld", 0, ld_cnt_o, 32'd0);
        chk("cnt_clr_st", 0, st_cnt_o, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 3)       drive(1, 0, W, 0, 32'(k * 4), 32'h0, 0);
            else if (k < 5)  drive(0, 1, W, 0, 32'h40, 32'(k), 0);
            else             drive(0, 1, W, 0, 32'h41, 32'h0, 0);
        end
        @(posedge clk);
        #1;
        chk("cnt_ld", 0, ld_cnt_o, 32'd3);
        chk("cnt_st", 0, st_cnt_o, 32'd2);
        @(negedge clk);
        drive(0, 0, W, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        drive(1, 0, W, 0, 32'h0, 32'h0, 0);
        force dut.ld_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.ld_cnt_q;
        @(posedge clk);
        #1;
        chk("cnt_wrap", 0, ld_cnt_o, 32'd0);
`endif

        @(negedge clk);
        drive(0, 0, W, 0, 32'h0, 32'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
